// File: rtl/mem_model_pkg.sv
// Shared types and constants for the latency-accurate memory model.
// Holds the FSM state type, LFSR constants and a clog2 helper.
package mem_model_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    for (int i = 0; i < 32; i++) begin
      if (x > 0) begin
        r++;
        x = x >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lat_lfsr.sv
// 8-bit Galois LFSR, stepped by en, reset to the package seed.
// Used only when MEM_RAND_LAT_EN is defined.
module lat_lfsr
  import mem_model_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_SEED;
    end else if (en) begin
      value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 8'h00);
    end
  end

endmodule

// File: rtl/lat_mem_model.sv
// Latency-accurate word memory with req/stall/ack handshake.
// Define MEM_RAND_LAT_EN for LFSR-driven per-access latency.
module lat_mem_model
  import mem_model_pkg::*;
#(
  parameter int WORD_DEPTH = 55,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LATENCY    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   offset,
  input  logic                req,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                stall,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int SHIFT = clog2(BE_W);
  localparam int IDX_W = (WORD_DEPTH > 1) ? clog2(WORD_DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? clog2(LATENCY) : 1;

  logic [DATA_W-1:0] mem [WORD_DEPTH];

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx, load;
  logic              cap_wen;
  logic [IDX_W-1:0]  cap_idx;
  logic [DATA_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;

  logic [ADDR_W-1:0] diff, word;
  logic              sel, accept, commit;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_data;
  logic [BE_W-1:0]   w_be;

  assign diff   = addr - offset;
  assign word   = diff >> SHIFT;
  assign sel    = (addr >= offset) && (word < ADDR_W'(WORD_DEPTH));
  assign accept = (state == IDLE) && req && sel;

`ifdef MEM_RAND_LAT_EN
  logic [7:0] lfsr;

  lat_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .value (lfsr)
  );

  assign load = CNT_W'(32'(lfsr) % LATENCY);
`else
  assign load = CNT_W'(LATENCY - 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_wen   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        cap_wen   <= wen;
        cap_idx   <= word[IDX_W-1:0];
        cap_wdata <= wdata;
        cap_be    <= be;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    ack      = 1'b0;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req && sel) begin
          stall    = 1'b1;
          cnt_nx   = load;
          state_nx = (load == '0) ? DONE : BUSY;
          commit   = wen && (load == '0);
        end
      end
      BUSY: begin
        stall  = 1'b1;
        cnt_nx = cnt - CNT_W'(1);
        if (cnt_nx == '0) begin
          state_nx = DONE;
          commit   = cap_wen;
        end
      end
      DONE: begin
        ack      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Zero-latency path commits straight from the inputs
  assign w_idx  = (state == IDLE) ? word[IDX_W-1:0] : cap_idx;
  assign w_data = (state == IDLE) ? wdata : cap_wdata;
  assign w_be   = (state == IDLE) ? be : cap_be;

  always_ff @(posedge clk) begin
    if (rst_n && commit) begin
      for (int i = 0; i < BE_W; i++) begin
        if (w_be[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  assign rdata = (state == DONE && !cap_wen) ? mem[cap_idx] : '0;

endmodule

// File: tb/tb_lat_mem_model.sv
// Self-checking bench for lat_mem_model against a word-array model.
// Build with MEM_RAND_LAT_EN to exercise the random-latency mode.
module tb_lat_mem_model;

  localparam int DEPTH = 55;
  localparam int LAT   = 4;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] offset;
  logic        req;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        stall;
  logic        ack;
  logic [31:0] rdata;

  logic [31:0] model [DEPTH];
  int n_chk  = 0;
  int n_fail = 0;

  lat_mem_model #(
    .WORD_DEPTH (DEPTH),
    .DATA_W     (32),
    .ADDR_W     (32),
    .LATENCY    (LAT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .offset (offset),
    .req    (req),
    .wen    (wen),
    .addr   (addr),
    .wdata  (wdata),
    .be     (be),
    .stall  (stall),
    .ack    (ack),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_lat(input string tag, input int lat);
`ifdef MEM_RAND_LAT_EN
    chk(tag, 32'(lat >= 1 && lat <= LAT), 32'd1);
`else
    chk(tag, 32'(lat), 32'(LAT));
`endif
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One handshake: starts just after a rising edge, ends in the cycle after ack
  task automatic access(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output int lat, output logic [31:0] rd,
                        output logic stall_ok, output logic after_zero);
    @(posedge clk);
    #1;
    req = 1'b1; wen = w; addr = a; wdata = d; be = b;
    lat = -1; rd = 'x; stall_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        lat = k;
        rd = rdata;
        if (stall !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    after_zero = (ack === 1'b0) && (rdata === 32'h0);
  endtask

  // Unselected request held for several cycles: nothing may respond
  task automatic oow(input logic [31:0] a, input logic w, output logic quiet);
    @(posedge clk);
    #1;
    req = 1'b1; wen = w; addr = a; wdata = $urandom; be = 4'hF;
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (stall !== 1'b0 || ack !== 1'b0 || rdata !== 32'h0) quiet = 1'b0;
    end
    req = 1'b0;
  endtask

  function automatic int mem_diffs();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (dut.mem[i] !== model[i]) n++;
    return n;
  endfunction

  initial begin
    int lat;
    logic [31:0] rd;
    logic sok, az, quiet;
    int idx;
    logic [31:0] a, d;
    logic [3:0] b;
    int seq1 [10];

    rst_n = 1'b0; offset = BASE; req = 1'b0; wen = 1'b0;
    addr = '0; wdata = '0; be = '0;
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = $urandom;
      dut.mem[i] = model[i];
    end
    model[3] = 32'h1234_5678;
    dut.mem[3] = 32'h1234_5678;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("preload_kept", dut.mem[3], 32'h1234_5678);

    access(1'b0, 32'h1001_000C, '0, '0, lat, rd, sok, az);
    chk_lat("rd_latency", lat);
    chk("rd_data", rd, 32'h1234_5678);
    chk("rd_stall", 32'(sok), 32'd1);
    chk("rd_after", 32'(az), 32'd1);

    access(1'b1, 32'h1001_000C, 32'hAABB_CCDD, 4'b0101, lat, rd, sok, az);
    model[3] = merge(model[3], 32'hAABB_CCDD, 4'b0101);
    chk_lat("wr_latency", lat);
    chk("wr_stall", 32'(sok), 32'd1);
    chk("wr_mem", dut.mem[3], 32'h12BB_56DD);
    access(1'b0, 32'h1001_000C, '0, '0, lat, rd, sok, az);
    chk("raw_data", rd, 32'h12BB_56DD);

    oow(32'h1001_00DC, 1'b1, quiet);
    chk("oow_high_quiet", 32'(quiet), 32'd1);
    oow(32'h1000_FFFC, 1'b0, quiet);
    chk("oow_low_quiet", 32'(quiet), 32'd1);
    chk("oow_mem", 32'(mem_diffs()), 32'd0);

    // Reset lands in cycle 2 of a write to word 7
    @(posedge clk);
    #1;
    req = 1'b1; wen = 1'b1; addr = BASE + 32'd28;
    wdata = ~model[7]; be = 4'hF;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack !== 1'b0 || stall !== 1'b0) quiet = 1'b0;
    end
    chk("midrst_no_ack", 32'(quiet), 32'd1);
    chk("midrst_word", dut.mem[7], model[7]);
    access(1'b0, BASE + 32'd28, '0, '0, lat, rd, sok, az);
    chk_lat("midrst_next_lat", lat);
    chk("midrst_next_data", rd, model[7]);

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, DEPTH - 1);
      a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      d = $urandom;
      b = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
        oow(a, 1'(n), quiet);
        chk("rnd_oow", 32'(quiet), 32'd1);
      end else if ($urandom_range(0, 1) == 1) begin
        access(1'b1, a, d, b, lat, rd, sok, az);
        model[idx] = merge(model[idx], d, b);
        chk_lat("rnd_wr_lat", lat);
        chk("rnd_wr_mem", dut.mem[idx], model[idx]);
        chk("rnd_wr_after", 32'(az), 32'd1);
      end else begin
        access(1'b0, a, '0, '0, lat, rd, sok, az);
        chk_lat("rnd_rd_lat", lat);
        chk("rnd_rd_data", rd, model[idx]);
        chk("rnd_rd_stall", 32'(sok), 32'd1);
        chk("rnd_rd_after", 32'(az), 32'd1);
      end
    end
    chk("final_mem", 32'(mem_diffs()), 32'd0);

`ifdef MEM_RAND_LAT_EN
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
        idx = $urandom_range(0, DEPTH - 1);
        access(1'b0, BASE + 32'(idx * 4), '0, '0, lat, rd, sok, az);
        chk_lat("rl_range", lat);
        chk("rl_data", rd, model[idx]);
        if (pass == 0) seq1[n] = lat;
        else chk("rl_repeat", 32'(lat), 32'(seq1[n]));
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lat_mem_model.md
# lat_mem_model

Parametrised, latency-accurate word memory model for the CHIP simulation environment; successor to the flat zero-wait memory. Serves one request at a time over a req/stall/ack handshake with configurable depth, data width, byte enables and access latency. Decodes its own address window from a runtime base offset. Drives zero read data when unselected, so several instances (text, data, stack) can share one CHIP bus by OR-ing `rdata`. The storage array stays hierarchically visible as `mem` for `$readmemh` preload and end-of-run comparison.

## Interface
- `WORD_DEPTH`, 55, number of words in the array
- `DATA_W`, 32, word width; multiple of 8
- `ADDR_W`, 32, byte-address width
- `LATENCY`, 4, cycles from request sample to ack; must be ≥1
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `offset` input ADDR_W — byte base address of this instance's window
- `req` input 1 — request valid
- `wen` input 1 — 1 = write, 0 = read
- `addr` input ADDR_W — byte address
- `wdata` input DATA_W — write data
- `be` input DATA_W/8 — byte enables for writes
- `stall` output 1 — access in progress; requester must hold inputs
- `ack` output 1 — one-cycle completion pulse
- `rdata` output DATA_W — read data, valid only while `ack`; otherwise 0

## Operation
- Select: `sel = (addr >= offset) && (((addr - offset) >> log2(DATA_W/8)) < WORD_DEPTH)`. Low log2(DATA_W/8) address bits ignored (no misalignment fault).
- FSM states: IDLE, BUSY, DONE.
- IDLE: `req && sel` → capture wen/index/wdata/be and load counter with LATENCY-1; go to BUSY, or to DONE if the counter is 0. `req && !sel` → stay IDLE, no stall, no ack.
- BUSY: decrement counter; at 0, go to DONE. All inputs ignored (the captured copy is used).
- DONE: `ack`=1. The write commits at the entry edge, per byte where `be[i]`=1. For reads, `rdata` = `mem[index]`. Go to IDLE unconditionally; `req` seen in DONE is ignored.
- `stall` = (IDLE && req && sel) || BUSY. `stall` is combinational in IDLE so the CPU freezes in the same cycle.
- Handshake: requester holds req/addr/wen/wdata/be stable until it sees ack. It may issue a new request from the cycle after ack.
- Read-after-write to the same word, issued after ack, returns the merged new data.
- Reset (any time, including mid-BUSY):
  - State goes to IDLE, counter to 0, `stall`=0, `ack`=0, `rdata`=0.
  - A pending write is dropped.
  - The `mem` array is never reset.

## Timing
- Request sampled at the end of cycle 0.
- `stall` is high in cycles 0..LATENCY-1.
- `ack` is high in cycle LATENCY only.
- Throughput: one access per LATENCY+1 cycles.
- LATENCY=1: stall in cycle 0 only, ack in cycle 1.
- Unselected request: zero cycles, stall stays 0, no state change.

## Configuration
- `MEM_RAND_LAT_EN` defined:
  - The per-access latency is `1 + (lfsr % LATENCY)`.
  - The LFSR is 8-bit maximal-length, seeded to 8'hA5 on reset, and advances once per accepted request.
  - Latency sequence is deterministic after reset.
- Not defined: fixed LATENCY, and no LFSR logic is instantiated.

## Structure
- Shared package `mem_model_pkg`:
  - FSM state typedef (IDLE/BUSY/DONE).
  - LFSR tap constant 8'hB8 and seed 8'hA5.
  - Counter-width function clog2.
- Sub-module `lat_lfsr`: 8-bit Galois LFSR with an enable input and an async active-low reset to the seed. It is instantiated only under `MEM_RAND_LAT_EN`.

## Test plan
- Reset: assert `rst_n`=0 → stall=0, ack=0, rdata=0. Preloaded `mem[3]`=32'h1234_5678 is intact after release.
- Read, LATENCY=4, offset=32'h1001_0000, addr=32'h1001_000C:
  - stall high cycles 0–3.
  - ack in cycle 4 with rdata=32'h1234_5678.
  - rdata=0 in cycle 5.
- Byte write: addr=32'h1001_000C, be=4'b0101, wdata=32'hAABB_CCDD onto 32'h1234_5678.
  - Required: mem[3]=32'h12BB_56DD after ack.
  - A following read returns the same value.
- Out of window, addr=32'h1001_00DC (index 55): stall never rises, ack never pulses, rdata=0, array unchanged.
- Reset mid-BUSY: pulse rst_n low in cycle 2 of a write → no ack, target word unchanged, next request serviced normally.
- With `MEM_RAND_LAT_EN`, LATENCY=4: ten back-to-back reads → each latency is in 1..4, and the sequence repeats identically after a second reset.
